// File: rtl/upsampling_pkg.sv
// Shared definitions for the nearest-neighbour upsampler.
// Holds default configuration values, the counter-width helper, counter
// widths for the default configuration, and the reader FSM state type.
// The top level recomputes widths from its own parameters with the same
// helper, so non-default configurations size their counters correctly.
package upsampling_pkg;

    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_IMAGE_WIDTH  = 16;
    localparam int DEF_IMAGE_HEIGHT = 16;
    localparam int DEF_CHANNEL_NUM  = 256;
    localparam int DEF_SCALE        = 4;

    // Width of a counter running 0..max_count-1, never narrower than one bit.
    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

    localparam int COL_W         = cnt_width(DEF_IMAGE_WIDTH);
    localparam int ROW_W         = cnt_width(DEF_IMAGE_HEIGHT);
    localparam int CH_W          = cnt_width(DEF_CHANNEL_NUM);
    localparam int REP_W         = cnt_width(DEF_SCALE);
    localparam int BEATS_PER_ROW = DEF_IMAGE_WIDTH * DEF_SCALE * DEF_SCALE;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } rd_state_e;

endpackage

// File: rtl/cnn_upsampling_nn_gen_if.sv
// Valid/ready pixel stream used on both sides of the upsampler.
//   valid : producer has a pixel
//   ready : consumer accepts the pixel
//   data  : pixel word
// master = producer side, slave = consumer side.
interface cnn_upsampling_nn_gen_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/upsampling_row_bank.sv
// Ping-pong row storage for the upsampler.
// Two banks of IMAGE_WIDTH words, one full flag per bank and the write/read
// bank pointers. A completed write row sets its flag and flips the write
// pointer; a release clears the read bank flag and flips the read pointer.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   wr_en, wr_last        pixel write strobe, write is last column of row
//   wr_col, wr_data       write column and pixel
//   rd_release            reader finished the current read bank
//   rd_bank_addr, rd_col  combinational read address
//   rd_data               word at (rd_bank_addr, rd_col)
//   full_wr, full_rd      flag of current write / read bank
//   full_other            flag of the bank the reader would move to next
//   rd_bank               current read bank pointer
module upsampling_row_bank
    import upsampling_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int IMAGE_WIDTH = DEF_IMAGE_WIDTH,
    parameter int COL_W       = cnt_width(IMAGE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  wr_last,
    input  logic [COL_W-1:0]      wr_col,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_release,
    input  logic                  rd_bank_addr,
    input  logic [COL_W-1:0]      rd_col,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full_wr,
    output logic                  full_rd,
    output logic                  full_other,
    output logic                  rd_bank
);

    logic [DATA_WIDTH-1:0] mem_q [2][IMAGE_WIDTH];
    logic [1:0]            full_q, full_d;
    logic                  wr_bank_q, wr_bank_d;
    logic                  rd_bank_q, rd_bank_d;

    // Flag and pointer updates; a fill and a release of the two different banks may coincide.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        if (wr_en && wr_last) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end else begin
            wr_bank_d = wr_bank_q;
        end
        if (rd_release) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end else begin
            rd_bank_d = rd_bank_q;
        end
    end

    // Flags and pointers; buffered rows are dropped on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    // Pixel storage; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_bank_q][wr_col] <= wr_data;
        end
    end

    assign rd_data    = mem_q[rd_bank_addr][rd_col];
    assign full_wr    = full_q[wr_bank_q];
    assign full_rd    = full_q[rd_bank_q];
    assign full_other = full_q[~rd_bank_q];
    assign rd_bank    = rd_bank_q;

endmodule

// File: rtl/cnn_upsampling_nn_gen.sv
// Nearest-neighbour upsampler: every input row is emitted SCALE times and
// every pixel within it SCALE times, buffering only two rows (ping-pong).
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   s_in         input pixel stream (slave): valid_in, ready_in, pxl_in
//   m_out        output pixel stream (master): valid_out, ready_out, pxl_out
//   frame_done   one-cycle pulse after the last beat of a frame
//                (present only when UPSAMPLING_FRAME_DONE_EN is defined)
module cnn_upsampling_nn_gen
    import upsampling_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
    parameter int CHANNEL_NUM  = DEF_CHANNEL_NUM,
    parameter int SCALE        = DEF_SCALE
) (
    input  logic                      clk,
    input  logic                      reset,
    cnn_upsampling_nn_gen_if.slave    s_in,
    cnn_upsampling_nn_gen_if.master   m_out
`ifdef UPSAMPLING_FRAME_DONE_EN
    ,
    output logic                      frame_done
`endif
);

    localparam int L_COL_W = cnt_width(IMAGE_WIDTH);
    localparam int L_ROW_W = cnt_width(IMAGE_HEIGHT);
    localparam int L_CH_W  = cnt_width(CHANNEL_NUM);
    localparam int L_REP_W = cnt_width(SCALE);

    // Writer
    logic [L_COL_W-1:0]    wcol_q, wcol_d;
    logic                  wr_fire_s;
    logic                  wr_last_s;

    // Bank interface
    logic                  full_wr_s, full_rd_s, full_other_s, rd_bank_s;
    logic                  rd_release_s;
    logic                  rd_bank_addr_s;
    logic [L_COL_W-1:0]    rd_col_s;
    logic [DATA_WIDTH-1:0] rd_data_s;

    // Reader
    rd_state_e             state_q, state_d;
    logic [L_REP_W-1:0]    rep_row_q, rep_row_d;
    logic [L_COL_W-1:0]    col_q, col_d;
    logic [L_REP_W-1:0]    rep_col_q, rep_col_d;
    logic [L_ROW_W-1:0]    row_q, row_d;
    logic [L_CH_W-1:0]     ch_q, ch_d;
    logic [DATA_WIDTH-1:0] pxl_q, pxl_d;
    logic                  valid_q, valid_d;
    logic                  out_fire_s;
    logic                  last_rep_col_s, last_col_s, last_rep_row_s, row_end_s;
    logic                  last_row_s, last_ch_s;
`ifdef UPSAMPLING_FRAME_DONE_EN
    logic                  fd_q, fd_d;
`endif

    upsampling_row_bank #(
        .DATA_WIDTH  (DATA_WIDTH),
        .IMAGE_WIDTH (IMAGE_WIDTH),
        .COL_W       (L_COL_W)
    ) u_bank (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_fire_s),
        .wr_last      (wr_last_s),
        .wr_col       (wcol_q),
        .wr_data      (s_in.data),
        .rd_release   (rd_release_s),
        .rd_bank_addr (rd_bank_addr_s),
        .rd_col       (rd_col_s),
        .rd_data      (rd_data_s),
        .full_wr      (full_wr_s),
        .full_rd      (full_rd_s),
        .full_other   (full_other_s),
        .rd_bank      (rd_bank_s)
    );

    // ready_in comes straight from the write bank flag, never from ready_out.
    assign s_in.ready = ~full_wr_s;
    assign m_out.valid = valid_q;
    assign m_out.data  = pxl_q;
`ifdef UPSAMPLING_FRAME_DONE_EN
    assign frame_done  = fd_q;
`endif

    // Writer column counter.
    always_comb begin
        wr_fire_s = s_in.valid && s_in.ready;
        wr_last_s = (wcol_q == L_COL_W'(IMAGE_WIDTH - 1));
        if (wr_fire_s) begin
            if (wr_last_s) begin
                wcol_d = '0;
            end else begin
                wcol_d = wcol_q + L_COL_W'(1);
            end
        end else begin
            wcol_d = wcol_q;
        end
    end

    // Position decode of the beat currently presented on pxl_out.
    always_comb begin
        out_fire_s     = valid_q && m_out.ready;
        last_rep_col_s = (rep_col_q == L_REP_W'(SCALE - 1));
        last_col_s     = (col_q == L_COL_W'(IMAGE_WIDTH - 1));
        last_rep_row_s = (rep_row_q == L_REP_W'(SCALE - 1));
        row_end_s      = last_rep_col_s && last_col_s && last_rep_row_s;
        last_row_s     = (row_q == L_ROW_W'(IMAGE_HEIGHT - 1));
        last_ch_s      = (ch_q == L_CH_W'(CHANNEL_NUM - 1));
    end

    // Reader FSM: counters point at the beat being shown; the bank is read at the next beat's address.
    always_comb begin
        state_d        = state_q;
        rep_row_d      = rep_row_q;
        col_d          = col_q;
        rep_col_d      = rep_col_q;
        row_d          = row_q;
        ch_d           = ch_q;
        pxl_d          = pxl_q;
        valid_d        = valid_q;
        rd_release_s   = 1'b0;
        rd_bank_addr_s = rd_bank_s;
        rd_col_s       = col_q;
`ifdef UPSAMPLING_FRAME_DONE_EN
        fd_d           = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (full_rd_s) begin
                    state_d  = EMIT;
                    rd_col_s = '0;
                    pxl_d    = rd_data_s;
                    valid_d  = 1'b1;
                end else begin
                    valid_d = 1'b0;
                end
            end
            EMIT: begin
                if (out_fire_s) begin
                    if (!last_rep_col_s) begin
                        rep_col_d = rep_col_q + L_REP_W'(1);
                    end else begin
                        rep_col_d = '0;
                        if (!last_col_s) begin
                            col_d = col_q + L_COL_W'(1);
                        end else begin
                            col_d = '0;
                            if (!last_rep_row_s) begin
                                rep_row_d = rep_row_q + L_REP_W'(1);
                            end else begin
                                rep_row_d = '0;
                            end
                        end
                    end
                    if (row_end_s) begin
                        // Release this bank and, if the other one is ready, start it with no bubble.
                        rd_release_s   = 1'b1;
                        rd_bank_addr_s = ~rd_bank_s;
                        rd_col_s       = '0;
                        if (last_row_s) begin
                            row_d = '0;
                            if (last_ch_s) begin
                                ch_d = '0;
`ifdef UPSAMPLING_FRAME_DONE_EN
                                fd_d = 1'b1;
`endif
                            end else begin
                                ch_d = ch_q + L_CH_W'(1);
                            end
                        end else begin
                            row_d = row_q + L_ROW_W'(1);
                        end
                        if (full_other_s) begin
                            state_d = EMIT;
                            pxl_d   = rd_data_s;
                            valid_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                            valid_d = 1'b0;
                        end
                    end else begin
                        rd_col_s = col_d;
                        pxl_d    = rd_data_s;
                        valid_d  = 1'b1;
                    end
                end else begin
                    // Stalled: everything holds.
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // Writer, reader state and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcol_q    <= '0;
            state_q   <= IDLE;
            rep_row_q <= '0;
            col_q     <= '0;
            rep_col_q <= '0;
            row_q     <= '0;
            ch_q      <= '0;
            pxl_q     <= '0;
            valid_q   <= 1'b0;
`ifdef UPSAMPLING_FRAME_DONE_EN
            fd_q      <= 1'b0;
`endif
        end else begin
            wcol_q    <= wcol_d;
            state_q   <= state_d;
            rep_row_q <= rep_row_d;
            col_q     <= col_d;
            rep_col_q <= rep_col_d;
            row_q     <= row_d;
            ch_q      <= ch_d;
            pxl_q     <= pxl_d;
            valid_q   <= valid_d;
`ifdef UPSAMPLING_FRAME_DONE_EN
            fd_q      <= fd_d;
`endif
        end
    end

endmodule

// File: tb/tb_cnn_upsampling_nn_gen.sv
// Self-checking bench for cnn_upsampling_nn_gen.
// Instance u_a: W=4, H=3, C=2, SCALE=2. Instance u_b: W=4, H=2, C=2, SCALE=1.
// The reference model expands each completed input row into SCALE rows of
// SCALE-times repeated pixels and tracks how many rows are buffered.
module tb_cnn_upsampling_nn_gen;

    localparam int DW   = 32;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int C    = 2;
    localparam int S    = 2;
    localparam int BPR  = W * S * S;
    localparam int FBT  = BPR * H * C;
    localparam int W1   = 4;
    localparam int H1   = 2;
    localparam int C1   = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cnn_upsampling_nn_gen_if #(.DATA_WIDTH(DW)) a_in ();
    cnn_upsampling_nn_gen_if #(.DATA_WIDTH(DW)) a_out ();
    cnn_upsampling_nn_gen_if #(.DATA_WIDTH(DW)) b_in ();
    cnn_upsampling_nn_gen_if #(.DATA_WIDTH(DW)) b_out ();
`ifdef UPSAMPLING_FRAME_DONE_EN
    logic fd_a;
    logic fd_b;
`endif

    cnn_upsampling_nn_gen #(
        .DATA_WIDTH(DW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .CHANNEL_NUM(C), .SCALE(S)
    ) u_a (
        .clk(clk), .reset(reset), .s_in(a_in), .m_out(a_out)
`ifdef UPSAMPLING_FRAME_DONE_EN
        , .frame_done(fd_a)
`endif
    );

    cnn_upsampling_nn_gen #(
        .DATA_WIDTH(DW), .IMAGE_WIDTH(W1), .IMAGE_HEIGHT(H1), .CHANNEL_NUM(C1), .SCALE(1)
    ) u_b (
        .clk(clk), .reset(reset), .s_in(b_in), .m_out(b_out)
`ifdef UPSAMPLING_FRAME_DONE_EN
        , .frame_done(fd_b)
`endif
    );

    int       vectors = 0;
    int       fails   = 0;
    int       cyc     = 0;
    int       exp_q[$];
    int       cur_row[$];
    int       obs_q[$];
    int       q1[$];
    int       nfull;
    int       beat_cnt;
    int       rows_in;
    int       row0_cyc;
    int       first_vo_cyc;
    int       fd_count;
    bit       fd_pend;
    bit       prev_stall;
    logic [DW-1:0] prev_pxl;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        cur_row.delete();
        obs_q.delete();
        q1.delete();
        nfull        = 0;
        beat_cnt     = 0;
        rows_in      = 0;
        row0_cyc     = -1;
        first_vo_cyc = -1;
        fd_count     = 0;
        fd_pend      = 1'b0;
        prev_stall   = 1'b0;
    endtask

    // Per-cycle compare against the model, sampled on the falling edge.
    task automatic monitor();
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                clear_model();
            end else begin
                check("ready_in", {31'd0, a_in.ready}, {31'd0, (nfull < 2)});
`ifdef UPSAMPLING_FRAME_DONE_EN
                check("frame_done", {31'd0, fd_a}, {31'd0, fd_pend});
                if (fd_a) fd_count++;
                fd_pend = 1'b0;
`endif
                if (prev_stall) begin
                    check("stall_valid", {31'd0, a_out.valid}, 32'd1);
                    check("stall_pxl", a_out.data, prev_pxl);
                end
                prev_stall = a_out.valid && !a_out.ready;
                prev_pxl   = a_out.data;
                if (a_out.valid && first_vo_cyc < 0) first_vo_cyc = cyc;
                if (a_out.valid && a_out.ready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        fails++;
                        $display("FAIL extra_beat: got %0h, expected no beat", a_out.data);
                    end else begin
                        check("pxl_out", a_out.data, exp_q.pop_front());
                    end
                    obs_q.push_back(int'(a_out.data));
                    beat_cnt++;
                    if (beat_cnt % BPR == 0) nfull--;
                    if (beat_cnt % FBT == 0) fd_pend = 1'b1;
                end
                if (a_in.valid && a_in.ready) begin
                    cur_row.push_back(int'(a_in.data));
                    if (cur_row.size() == W) begin
                        for (int r = 0; r < S; r++)
                            for (int c = 0; c < W; c++)
                                for (int k = 0; k < S; k++)
                                    exp_q.push_back(cur_row[c]);
                        cur_row.delete();
                        nfull++;
                        rows_in++;
                        if (rows_in == 1) row0_cyc = cyc;
                    end
                end
                if (b_out.valid && b_out.ready) begin
                    if (q1.size() == 0) begin
                        vectors++;
                        fails++;
                        $display("FAIL s1_extra: got %0h, expected no beat", b_out.data);
                    end else begin
                        check("s1_pxl_out", b_out.data, q1.pop_front());
                    end
                end
                if (b_in.valid && b_in.ready) q1.push_back(int'(b_in.data));
            end
        end
    endtask

    // Push n_a pixels into u_a (seq_a != 0: seq_a, seq_a+1, ...; else random) and n_b random pixels into u_b.
    task automatic drive(input int n_a, input int seq_a, input int n_b,
                         input int vpct, input int rpct, input int budget);
        int sa = 0;
        int sb = 0;
        int t  = 0;
        bit acc_a = 1'b1;
        bit acc_b = 1'b1;
        while ((sa < n_a || sb < n_b) && t < budget) begin
            @(posedge clk);
            #1;
            if (acc_a || !a_in.valid) begin
                a_in.valid = (sa < n_a) && ($urandom_range(99) < vpct);
                a_in.data  = (seq_a != 0) ? DW'(seq_a + sa) : DW'($urandom);
            end
            if (acc_b || !b_in.valid) begin
                b_in.valid = (sb < n_b) && ($urandom_range(99) < vpct);
                b_in.data  = DW'($urandom);
            end
            a_out.ready = ($urandom_range(99) < rpct);
            b_out.ready = ($urandom_range(99) < rpct);
            @(negedge clk);
            acc_a = a_in.valid && a_in.ready;
            acc_b = b_in.valid && b_in.ready;
            if (acc_a) sa++;
            if (acc_b) sb++;
            t++;
        end
        @(posedge clk);
        #1;
        a_in.valid = 1'b0;
        b_in.valid = 1'b0;
        check("drive_done", DW'(sa + sb), DW'(n_a + n_b));
    endtask

    // Let both instances emit everything the model still expects.
    task automatic drain(input int rpct, input int budget);
        int t = 0;
        while ((exp_q.size() != 0 || q1.size() != 0) && t < budget) begin
            @(posedge clk);
            #1;
            a_out.ready = ($urandom_range(99) < rpct);
            b_out.ready = ($urandom_range(99) < rpct);
            @(negedge clk);
            #2;
            t++;
        end
        @(posedge clk);
        #1;
        a_out.ready = 1'b1;
        b_out.ready = 1'b1;
        repeat (3) @(posedge clk);
        check("drain_left", DW'(exp_q.size() + q1.size()), 32'd0);
    endtask

    int lit[16] = '{1, 1, 2, 2, 3, 3, 4, 4, 1, 1, 2, 2, 3, 3, 4, 4};

    initial begin
        reset       = 1'b1;
        a_in.valid  = 1'b0;
        a_in.data   = '0;
        b_in.valid  = 1'b0;
        b_in.data   = '0;
        a_out.ready = 1'b1;
        b_out.ready = 1'b1;
        clear_model();
        fork
            monitor();
        join_none

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_out", {31'd0, a_out.valid}, 32'd0);
        check("rst_pxl_out", a_out.data, 32'd0);
        check("rst_ready_in", {31'd0, a_in.ready}, 32'd1);
`ifdef UPSAMPLING_FRAME_DONE_EN
        check("rst_frame_done", {31'd0, fd_a}, 32'd0);
`endif
        reset = 1'b0;

        // Basic 2x: row 1,2,3,4
        drive(4, 1, 0, 100, 100, 50);
        drain(100, 200);
        check("basic_beats", DW'(obs_q.size()), 32'd16);
        for (int i = 0; i < 16; i++)
            if (i < obs_q.size()) check("basic_seq", DW'(obs_q[i]), DW'(lit[i]));
        check("latency", DW'(first_vo_cyc - row0_cyc), 32'd2);

        // Output stall for 5 cycles mid-row
        drive(4, 5, 0, 100, 100, 50);
        repeat (3) @(posedge clk);
        #1;
        a_out.ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        a_out.ready = 1'b1;
        drain(100, 200);

        // Reset after 3 of 4 pixels of a row
        drive(3, 9, 0, 100, 100, 50);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("midrst_valid_out", {31'd0, a_out.valid}, 32'd0);
        check("midrst_pxl_out", a_out.data, 32'd0);
        check("midrst_ready_in", {31'd0, a_in.ready}, 32'd1);
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(4, 20, 0, 100, 100, 50);
        drain(100, 200);
        check("midrst_beats", DW'(obs_q.size()), 32'd16);
        if (obs_q.size() == 16) begin
            check("midrst_first", DW'(obs_q[0]), 32'd20);
            check("midrst_last", DW'(obs_q[15]), 32'd23);
        end

        // Two frames of random pixels with random throttling on both sides
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(W * H * C * 2, 0, W1 * H1 * C1 * 2, 85, 60, 8000);
        drain(60, 8000);
        check("frames_beats", DW'(beat_cnt), 32'd192);
        check("partial_row", DW'(cur_row.size()), 32'd0);
`ifdef UPSAMPLING_FRAME_DONE_EN
        check("frame_done_count", DW'(fd_count), 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/cnn_upsampling_nn_gen.md
# cnn_upsampling_nn_gen

Parametrised nearest-neighbour upsampler for the DeepLabV3+ decoder path: it takes a channel-major raster pixel stream and emits each input row SCALE times, each pixel repeated SCALE times. It buffers two input rows (ping-pong) instead of a whole feature map. Both ports use valid/ready handshakes, so it can sit between any two streaming CNN stages, including ones that stall.

## Interface
- DATA_WIDTH, 32, pixel word width
- IMAGE_WIDTH, 16, input pixels per row
- IMAGE_HEIGHT, 16, input rows per channel
- CHANNEL_NUM, 256, channels per frame
- SCALE, 4, integer upsampling factor; legal range 1..8
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- valid_in  input  1  input pixel valid
- ready_in  output  1  block can accept an input pixel
- pxl_in  input  DATA_WIDTH  input pixel
- valid_out  output  1  output pixel valid
- ready_out  input  1  downstream accepts an output pixel
- pxl_out  output  DATA_WIDTH  output pixel, registered

## Operation
- **Input.** An input beat is transferred when valid_in && ready_in. Input order is channel, then row, then column.
- **Row banks.** Two row banks, each IMAGE_WIDTH words, each with a full flag.
  - The writer fills the current write bank at column wcol.
  - On the transfer of the last column of a row, it sets that bank's full flag and toggles the write bank.
- **ready_in.** Equals !full[write bank]. It is 1 out of reset.
- **Reader FSM.**
  - IDLE → EMIT when full[read bank] is set.
  - In EMIT, the emission order is rep_row 0..SCALE-1, then col 0..IMAGE_WIDTH-1, then rep_col 0..SCALE-1.
  - That gives IMAGE_WIDTH·SCALE² beats per input row.
- **Counter advance.** Counters advance only on an output transfer (valid_out && ready_out).
- **End of row.** The transfer of the last beat of a row does all of the following:
  - clears the full flag of the read bank;
  - toggles the read bank;
  - moves to EMIT if the other bank is full, otherwise to IDLE. There is no bubble between back-to-back rows.
- **Row and channel counters.**
  - The row counter wraps at IMAGE_HEIGHT and increments the channel counter.
  - The channel counter wraps to 0 at CHANNEL_NUM, which is the end of the frame.
  - A new frame needs no restart.
- **Output stall.** While valid_out=1 && ready_out=0, pxl_out and valid_out stay stable and all reader counters hold.
- **Counter widths.** Each counter is sized $clog2 of its maximum, minimum 1 bit. There is no arithmetic overflow: every counter wraps explicitly by compare-and-clear.
- **Simultaneous events.**
  - If a bank is released and the writer completes the other bank in the same cycle, both flag updates apply.
  - If the writer wants the bank being released, ready_in rises the following cycle. No combinational ready path exists.
- **Reset, including mid-frame.** Asynchronous clear of:
  - all counters;
  - both full flags;
  - bank pointers, set to 0;
  - the FSM, set to IDLE.

  Partially buffered rows are discarded. Bank contents are not reset.
- **Reset values of outputs.** pxl_out=0, valid_out=0, ready_in=1, frame_done=0 (when present).
- **SCALE=1.** The block acts as a one-row-delayed pass-through.

## Timing
- **Latency.** The last input pixel of a row transfers in cycle t. The full flag is visible in cycle t+1. With the reader in IDLE, the first pxl_out/valid_out of that row is valid in cycle t+2.
- **Output throughput.** One beat per cycle while ready_out=1.
- **Input throughput.** One pixel per cycle while a bank is free.
- **Steady state.** Input is throttled to 1/SCALE² of the output rate once both banks are full.
- **Reads.** The bank is read combinationally at the (bank, col) address and captured into pxl_out on the edge that loads or advances the output.

## Configuration
- **UPSAMPLING_FRAME_DONE_EN defined.** Adds output port frame_done (1 bit, reset 0). It pulses high for exactly one cycle, coincident with the cycle after the transfer of the final output beat of channel CHANNEL_NUM-1, row IMAGE_HEIGHT-1.
- **Undefined.** The port and its logic are absent. All other behaviour is identical.

## Structure
- **Package upsampling_pkg.** Holds:
  - localparams for counter widths (COL_W, ROW_W, CH_W, REP_W);
  - BEATS_PER_ROW = IMAGE_WIDTH·SCALE²;
  - a typedef for reader FSM states {IDLE, EMIT}.
- **Sub-module upsampling_row_bank.** Holds the two IMAGE_WIDTH×DATA_WIDTH banks, their full flags, and the write/read bank pointers. It is instanced once. The top level holds the writer counters, the reader FSM/counters and the output register.

## Test plan
- **Basic 2× upsample.** Config W=4, H=2, C=1, S=2, ready_out=1. Input row 1,2,3,4. Required: 16 output beats 1,1,2,2,3,3,4,4,1,1,2,2,3,3,4,4, first valid_out 2 cycles after pixel 4.
- **Output stall.** Same config, ready_out low for 5 cycles mid-row. Required: pxl_out/valid_out held stable, no beat lost or duplicated, order unchanged.
- **Back-pressure.** Continuous valid_in with S=4. Required: ready_in drops after 2 rows buffered, and reassertion follows each row release by 1 cycle; the full 16×16 image produces exactly 4096 beats per channel.
- **Channel/frame wrap.** C=2, two back-to-back frames. Required: exact repeated sequence per channel, counters wrap without stall; with UPSAMPLING_FRAME_DONE_EN, exactly one frame_done pulse per frame.
- **Reset mid-row.** Assert reset after 3 of 4 pixels of row 0. Required: outputs at reset values immediately, and the next full row emits correctly with no stale beats.
- **SCALE=1.** Required: output stream equals input stream.
